// File: rtl/mbist_march_ctrl_pkg.sv
// Shared types and constants for the March C- MBIST controller.
//   state_e      : controller states (IDLE, WRITE, READ, CHECK, DONE)
//   march_elem_e : March C- elements M0..M5
//   elem_cfg_t   : per-element sweep direction, read/write ops and patterns
package mbist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_CHECK,
    ST_DONE
  } state_e;

  typedef enum logic [2:0] {
    M0,
    M1,
    M2,
    M3,
    M4,
    M5
  } march_elem_e;

  // up: ascending sweep; rd/wr: op present; *_pat: 0 = all zeros, 1 = all ones
  typedef struct packed {
    logic up;
    logic rd;
    logic rd_pat;
    logic wr;
    logic wr_pat;
  } elem_cfg_t;

  localparam elem_cfg_t CFG_M0 = '{up: 1'b1, rd: 1'b0, rd_pat: 1'b0, wr: 1'b1, wr_pat: 1'b0};
  localparam elem_cfg_t CFG_M1 = '{up: 1'b1, rd: 1'b1, rd_pat: 1'b0, wr: 1'b1, wr_pat: 1'b1};
  localparam elem_cfg_t CFG_M2 = '{up: 1'b1, rd: 1'b1, rd_pat: 1'b1, wr: 1'b1, wr_pat: 1'b0};
  localparam elem_cfg_t CFG_M3 = '{up: 1'b0, rd: 1'b1, rd_pat: 1'b0, wr: 1'b1, wr_pat: 1'b1};
  localparam elem_cfg_t CFG_M4 = '{up: 1'b0, rd: 1'b1, rd_pat: 1'b1, wr: 1'b1, wr_pat: 1'b0};
  localparam elem_cfg_t CFG_M5 = '{up: 1'b0, rd: 1'b1, rd_pat: 1'b0, wr: 1'b0, wr_pat: 1'b0};

  // Element table lookup
  function automatic elem_cfg_t elem_cfg(input march_elem_e e);
    case (e)
      M0:      return CFG_M0;
      M1:      return CFG_M1;
      M2:      return CFG_M2;
      M3:      return CFG_M3;
      M4:      return CFG_M4;
      default: return CFG_M5;
    endcase
  endfunction

  // Element sequencing; M5 is terminal
  function automatic march_elem_e next_elem(input march_elem_e e);
    case (e)
      M0:      return M1;
      M1:      return M2;
      M2:      return M3;
      M3:      return M4;
      default: return M5;
    endcase
  endfunction

endpackage

// File: rtl/mbist_march_ctrl_if.sv
// Bus bundle between the MBIST controller and its RAM/comparator side.
//   master modport: controller (drives RAM controls and status)
//   slave  modport: RAM/comparator side (drives start and eq)
interface mbist_march_ctrl_if #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 8
);
  logic              start;
  logic              eq;
  logic              cen;
  logic              rwbar;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] data_t;
  logic              busy;
  logic              done;
  logic              fail;
  logic [ADDR_W-1:0] fail_addr;

  modport master (
    input  start, eq,
    output cen, rwbar, address, data_t, busy, done, fail, fail_addr
  );

  modport slave (
    output start, eq,
    input  cen, rwbar, address, data_t, busy, done, fail, fail_addr
  );
endinterface

// File: rtl/mbist_march_ctrl_addr_counter.sv
// Address counter for the March sweep.
//   clk, rst    : clock, async active-high reset (count -> 0)
//   load_i      : load 0 (load_top_i=0) or N-1 (load_top_i=1)
//   en_i, up_i  : step by one, ascending when up_i
//   cnt_o       : current address
//   tc_o        : terminal count for the current direction
module mbist_addr_counter #(
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              load_top_i,
  input  logic              en_i,
  input  logic              up_i,
  output logic [ADDR_W-1:0] cnt_o,
  output logic              tc_o
);
  localparam logic [ADDR_W-1:0] TOP = '1;

  logic [ADDR_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_top_i ? TOP : '0;
    end else if (en_i) begin
      cnt_q <= up_i ? cnt_q + ADDR_W'(1) : cnt_q - ADDR_W'(1);
    end
  end

  assign cnt_o = cnt_q;
  assign tc_o  = up_i ? (cnt_q == TOP) : (cnt_q == '0);
endmodule

// File: rtl/mbist_march_ctrl.sv
// March C- memory BIST controller (15*N cycles per test).
//   clk, rst : clock, async active-high reset
//   bus      : mbist_march_ctrl_if.master -- start/eq in; cen, rwbar,
//              address, data_t, busy, done, fail, fail_addr out
// Build option: define MBIST_FAIL_LOG_EN to capture the first miscompare
// address in fail_addr; otherwise fail_addr is tied to 0.
import mbist_pkg::*;

module mbist_march_ctrl #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  mbist_march_ctrl_if.master  bus
);
  state_e            state_q;
  march_elem_e       elem_q;
  logic              cen_q, rwbar_q, busy_q, done_q, fail_q;
  logic [DATA_W-1:0] data_q;

  logic [ADDR_W-1:0] addr;
  logic              tc;

  elem_cfg_t         cfg_c, nxt_cfg_c;
  march_elem_e       nxt_elem_c;
  logic              accept_c, last_op_c, finish_c, miscmp_c;
  logic              cnt_load_c, cnt_top_c, cnt_en_c;

  function automatic logic [DATA_W-1:0] pat(input logic b);
    return {DATA_W{b}};
  endfunction

  // Sequencing decisions: when an address is finished, step or move to the next element
  always_comb begin
    cfg_c      = elem_cfg(elem_q);
    accept_c   = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && bus.start;
    last_op_c  = (state_q == ST_WRITE) || ((state_q == ST_CHECK) && !cfg_c.wr);
    finish_c   = last_op_c && tc && (elem_q == M5);
    miscmp_c   = (state_q == ST_CHECK) && !bus.eq;
    nxt_elem_c = elem_q;
    if (last_op_c && tc && (elem_q != M5)) begin
      nxt_elem_c = next_elem(elem_q);
    end
    nxt_cfg_c  = elem_cfg(nxt_elem_c);
    cnt_load_c = accept_c || (last_op_c && tc && !finish_c);
    cnt_top_c  = !accept_c && !nxt_cfg_c.up;
    cnt_en_c   = last_op_c && !tc;
  end

  logic unused_cfg_c;
  assign unused_cfg_c = ^{cfg_c.rd, cfg_c.rd_pat, nxt_cfg_c.wr};

  mbist_addr_counter #(.ADDR_W(ADDR_W)) u_addr_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (cnt_load_c),
    .load_top_i (cnt_top_c),
    .en_i       (cnt_en_c),
    .up_i       (cfg_c.up),
    .cnt_o      (addr),
    .tc_o       (tc)
  );

  // Controller FSM with registered RAM controls and status
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      elem_q  <= M0;
      cen_q   <= 1'b0;
      rwbar_q <= 1'b1;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            state_q <= ST_WRITE;
            elem_q  <= M0;
            cen_q   <= 1'b1;
            rwbar_q <= 1'b0;
            data_q  <= pat(1'b0);
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            fail_q  <= 1'b0;
          end
        end
        ST_READ: begin
          // RAM data arrives next cycle; hold address and expected data
          state_q <= ST_CHECK;
          cen_q   <= 1'b0;
        end
        ST_WRITE, ST_CHECK: begin
          if (miscmp_c) begin
            fail_q <= 1'b1;
          end
          if ((state_q == ST_CHECK) && cfg_c.wr) begin
            state_q <= ST_WRITE;
            cen_q   <= 1'b1;
            rwbar_q <= 1'b0;
            data_q  <= pat(cfg_c.wr_pat);
          end else if (finish_c) begin
            state_q <= ST_DONE;
            cen_q   <= 1'b0;
            rwbar_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            elem_q <= nxt_elem_c;
            cen_q  <= 1'b1;
            if (nxt_cfg_c.rd) begin
              state_q <= ST_READ;
              rwbar_q <= 1'b1;
              data_q  <= pat(nxt_cfg_c.rd_pat);
            end else begin
              state_q <= ST_WRITE;
              rwbar_q <= 1'b0;
              data_q  <= pat(nxt_cfg_c.wr_pat);
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef MBIST_FAIL_LOG_EN
  logic [ADDR_W-1:0] fail_addr_q;

  // First-miscompare address; later miscompares leave it alone
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fail_addr_q <= '0;
    end else if (accept_c) begin
      fail_addr_q <= '0;
    end else if (miscmp_c && !fail_q) begin
      fail_addr_q <= addr;
    end
  end

  assign bus.fail_addr = fail_addr_q;
`else
  assign bus.fail_addr = '0;
`endif

  assign bus.cen     = cen_q;
  assign bus.rwbar   = rwbar_q;
  assign bus.address = addr;
  assign bus.data_t  = data_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.fail    = fail_q;
endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Self-checking bench for mbist_march_ctrl (ADDR_W=2, N=4).
// A reference op list is built from the March C- element description;
// expected fail timing/address comes from replaying that list on an array
// memory carrying the same injected stuck-at fault as the RAM model.
module tb_mbist_march_ctrl;
  localparam int unsigned ADDR_W = 2;
  localparam int unsigned DATA_W = 8;
  localparam int          N      = 4;
  localparam int          NOPS   = 15 * N;

  logic clk;
  logic rst;

  mbist_march_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mbist_march_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Fault configuration shared by the RAM and the reference replay
  bit       fault_en;
  int       fault_addr;
  int       fault_bit;
  bit       fault_val;

  function automatic logic [7:0] inj(input int a, input logic [7:0] d);
    logic [7:0] r;
    r = d;
    if (fault_en && (a == fault_addr)) r[fault_bit] = fault_val;
    return r;
  endfunction

  // Synchronous RAM, 1-cycle read latency, comparator on its output
  logic [7:0] mem [N];
  logic [7:0] ramout;
  initial ramout = 8'h00;

  always @(posedge clk) begin
    if (bus.cen) begin
      if (!bus.rwbar) mem[bus.address] <= inj(int'(bus.address), bus.data_t);
      else            ramout <= mem[bus.address];
    end
  end

  assign bus.eq = (ramout == bus.data_t);

  // Reference op list: one entry per cycle of the test
  int e_cen  [NOPS];
  int e_rw   [NOPS];
  int e_addr [NOPS];
  int e_data [NOPS];

  task automatic build_ref();
    int up_t [6];
    int rd_t [6];
    int wr_t [6];
    int n;
    int a;
    up_t = '{1, 1, 1, 0, 0, 0};
    rd_t = '{-1, 0, 1, 0, 1, 0};
    wr_t = '{0, 1, 0, 1, 0, -1};
    n = 0;
    for (int e = 0; e < 6; e++) begin
      for (int i = 0; i < N; i++) begin
        a = (up_t[e] != 0) ? i : (N - 1 - i);
        if (rd_t[e] >= 0) begin
          e_cen[n] = 1; e_rw[n] = 1; e_addr[n] = a; e_data[n] = (rd_t[e] != 0) ? 255 : 0; n++;
          e_cen[n] = 0; e_rw[n] = 1; e_addr[n] = a; e_data[n] = (rd_t[e] != 0) ? 255 : 0; n++;
        end
        if (wr_t[e] >= 0) begin
          e_cen[n] = 1; e_rw[n] = 0; e_addr[n] = a; e_data[n] = (wr_t[e] != 0) ? 255 : 0; n++;
        end
      end
    end
  endtask

  // Replay reference ops; returns cycle index of first failing CHECK (-1 if none)
  task automatic predict(output int first_chk, output int first_addr);
    logic [7:0] m [N];
    first_chk  = -1;
    first_addr = 0;
    for (int i = 0; i < N; i++) m[i] = 8'h00;
    for (int k = 0; k < NOPS; k++) begin
      if (e_cen[k] == 1 && e_rw[k] == 0) m[e_addr[k]] = inj(e_addr[k], 8'(e_data[k]));
      if (e_cen[k] == 1 && e_rw[k] == 1 && first_chk < 0 && int'(m[e_addr[k]]) != e_data[k]) begin
        first_chk  = k + 1;
        first_addr = e_addr[k];
      end
    end
  endtask

  int errors;
  int checks;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, ".cen"},       32'(bus.cen),       32'd0);
    check({tag, ".rwbar"},     32'(bus.rwbar),     32'd1);
    check({tag, ".address"},   32'(bus.address),   32'd0);
    check({tag, ".data_t"},    32'(bus.data_t),    32'd0);
    check({tag, ".busy"},      32'(bus.busy),      32'd0);
    check({tag, ".done"},      32'(bus.done),      32'd0);
    check({tag, ".fail"},      32'(bus.fail),      32'd0);
    check({tag, ".fail_addr"}, 32'(bus.fail_addr), 32'd0);
  endtask

  // One test run. Called right after a falling edge. repulse_at/abort_at < 0 disables.
  task automatic run_test(input string tag, input int repulse_at, input int abort_at);
    int fc;
    int fa;
    int exp_fa;
    string t;
    predict(fc, fa);
`ifdef MBIST_FAIL_LOG_EN
    exp_fa = (fc >= 0) ? fa : 0;
`else
    exp_fa = 0;
`endif
    bus.start = 1'b1;
    @(negedge clk);
    for (int k = 0; k < NOPS; k++) begin
      bus.start = 1'b0;
      t = $sformatf("%s.c%0d", tag, k);
      check({t, ".cen"},     32'(bus.cen),     32'(e_cen[k]));
      if (e_cen[k] == 1) check({t, ".rwbar"}, 32'(bus.rwbar), 32'(e_rw[k]));
      check({t, ".address"}, 32'(bus.address), 32'(e_addr[k]));
      check({t, ".data_t"},  32'(bus.data_t),  32'(e_data[k]));
      check({t, ".busy"},    32'(bus.busy),    32'd1);
      check({t, ".done"},    32'(bus.done),    32'd0);
      check({t, ".fail"},    32'(bus.fail),    (fc >= 0 && k > fc) ? 32'd1 : 32'd0);
      if (k == 0) check({t, ".fail_addr"}, 32'(bus.fail_addr), 32'd0);
      if (k == abort_at) begin
        rst = 1'b1;
        @(negedge clk);
        check_reset({tag, ".rst"});
        rst = 1'b0;
        return;
      end
      if (k == repulse_at) bus.start = 1'b1;
      @(negedge clk);
    end
    bus.start = 1'b0;
    check({tag, ".end.done"},      32'(bus.done),      32'd1);
    check({tag, ".end.busy"},      32'(bus.busy),      32'd0);
    check({tag, ".end.cen"},       32'(bus.cen),       32'd0);
    check({tag, ".end.fail"},      32'(bus.fail),      (fc >= 0) ? 32'd1 : 32'd0);
    check({tag, ".end.fail_addr"}, 32'(bus.fail_addr), 32'(exp_fa));
    @(negedge clk);
    check({tag, ".hold.done"}, 32'(bus.done), 32'd1);
    check({tag, ".hold.cen"},  32'(bus.cen),  32'd0);
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    fault_en  = 1'b0;
    fault_addr = 0;
    fault_bit  = 0;
    fault_val  = 1'b0;
    build_ref();
    repeat (2) @(negedge clk);
    check_reset("por");
    rst = 1'b0;
    @(negedge clk);
    check_reset("idle");

    run_test("clean", -1, -1);

    fault_en = 1'b1; fault_addr = 2; fault_bit = 3; fault_val = 1'b0;
    run_test("sa0_a2b3", -1, -1);

    fault_en = 1'b0;
    run_test("restart_clear", -1, -1);

    run_test("repulse", 10, -1);

    run_test("abort_m3", -1, 32);
    run_test("after_abort", -1, -1);

    for (int r = 0; r < 4; r++) begin
      fault_en   = 1'b1;
      fault_addr = int'($urandom_range(0, N - 1));
      fault_bit  = int'($urandom_range(0, DATA_W - 1));
      fault_val  = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_test($sformatf("rnd%0d_a%0db%0dv%0d", r, fault_addr, fault_bit, fault_val), -1, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
